// File: rtl/gb_timer_intc.sv
// gb_timer_intc: CPU-bus responder for the interrupt flag/enable registers
// and the DIV/TIMA/TMA/TAC timer, including the TIMA overflow reload sequence.
module gb_timer_intc (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr_i,
   input  logic [7:0]  data_i,
   input  logic        wren_i,
   input  logic [4:0]  irq_req_i,
   input  logic [4:0]  irq_ack_i,
   output logic [7:0]  data_o,
   output logic        sel_o,
   output logic [7:0]  reg_IF,
   output logic [7:0]  reg_IE
);

   typedef enum logic {
      IDLE,
      RELOAD
   } state_t;

   state_t      state;
   logic [15:0] sys_cnt;
   logic [7:0]  tima;
   logic [7:0]  tma;
   logic [2:0]  tac;
   logic [4:0]  if_r;
   logic [7:0]  ie;
   logic        tap_q;

   logic        wr_div, wr_tima, wr_tma, wr_tac, wr_if, wr_ie;
   logic        tap_bit, tap, tick, timer_req;

   // Write strobes per register
   always_comb begin
      wr_div  = wren_i && (addr_i == 16'hFF04);
      wr_tima = wren_i && (addr_i == 16'hFF05);
      wr_tma  = wren_i && (addr_i == 16'hFF06);
      wr_tac  = wren_i && (addr_i == 16'hFF07);
      wr_if   = wren_i && (addr_i == 16'hFF0F);
      wr_ie   = wren_i && (addr_i == 16'hFFFF);
   end

   // Timer tap from the current counter/TAC; a falling tap is a TIMA tick
   always_comb begin
      case (tac[1:0])
         2'b00:   tap_bit = sys_cnt[9];
         2'b01:   tap_bit = sys_cnt[3];
         2'b10:   tap_bit = sys_cnt[5];
         default: tap_bit = sys_cnt[7];
      endcase
      tap       = tac[2] & tap_bit;
      tick      = tap_q & ~tap;
      // a TIMA write during RELOAD suppresses the interrupt as well as the reload
      timer_req = (state == RELOAD) && !wr_tima;
   end

   // Combinational read mux
   always_comb begin
      data_o = '1;
      sel_o  = 1'b1;
      case (addr_i)
         16'hFF04: data_o = sys_cnt[15:8];
         16'hFF05: data_o = tima;
         16'hFF06: data_o = tma;
         16'hFF07: data_o = {5'b11111, tac};
         16'hFF0F: data_o = {3'b111, if_r};
         16'hFFFF: data_o = ie;
         default:  sel_o  = 1'b0;
      endcase
      reg_IF = {3'b000, if_r};
      reg_IE = ie;
   end

   // Free-running T-cycle counter, tap history and plain config registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sys_cnt <= '0;
         tap_q   <= 1'b0;
         tma     <= '0;
         tac     <= '0;
         ie      <= '0;
      end else begin
         sys_cnt <= wr_div ? '0 : sys_cnt + 16'd4;
         tap_q   <= tap;
         if (wr_tma) tma <= data_i;
         if (wr_tac) tac <= data_i[2:0];
         if (wr_ie)  ie  <= data_i;
      end
   end

   // TIMA counter with overflow FSM: write beats reload, reload beats tick
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tima  <= '0;
         state <= IDLE;
      end else if (wr_tima) begin
         tima  <= data_i;
         state <= IDLE;
      end else if (state == RELOAD) begin
         tima  <= wr_tma ? data_i : tma;
         state <= IDLE;
      end else if (tick) begin
         if (tima == 8'hFF) begin
            tima  <= '0;
            state <= RELOAD;
         end else begin
            tima  <= tima + 8'd1;
         end
      end
   end

   // Interrupt flags: set requests dominate writes and acks
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         if_r <= '0;
      end else begin
         if_r <= ((wr_if ? data_i[4:0] : if_r) & ~irq_ack_i)
                 | irq_req_i | {2'b00, timer_req, 2'b00};
      end
   end

endmodule

// File: tb/tb_gb_timer_intc.sv
// tb_gb_timer_intc: directed checks of the timer/interrupt responder followed
// by randomized bus traffic compared against a behavioural reference model.
module tb_gb_timer_intc;

   logic        clk;
   logic        reset;
   logic [15:0] addr_i;
   logic [7:0]  data_i;
   logic        wren_i;
   logic [4:0]  irq_req_i;
   logic [4:0]  irq_ack_i;
   logic [7:0]  data_o;
   logic        sel_o;
   logic [7:0]  reg_IF;
   logic [7:0]  reg_IE;

   int checks = 0;
   int errors = 0;

   // reference model state
   int unsigned m_cnt, m_tima, m_tma, m_tac, m_if, m_ie;
   bit          m_reload, m_tapq;

   gb_timer_intc dut (
      .clk       (clk),
      .reset     (reset),
      .addr_i    (addr_i),
      .data_i    (data_i),
      .wren_i    (wren_i),
      .irq_req_i (irq_req_i),
      .irq_ack_i (irq_ack_i),
      .data_o    (data_o),
      .sel_o     (sel_o),
      .reg_IF    (reg_IF),
      .reg_IE    (reg_IE)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0; m_if = 0; m_ie = 0;
      m_reload = 0; m_tapq = 0;
   endtask

   // selected divider output: bit 9/3/5/7 of the T-cycle count, gated by enable
   function automatic bit m_tap(input int unsigned cnt, input int unsigned tac);
      int unsigned half;
      case (tac % 4)
         0:       half = 512;
         1:       half = 8;
         2:       half = 32;
         default: half = 128;
      endcase
      return (tac >= 4) && (((cnt / half) % 2) == 1);
   endfunction

   task automatic model_step(input logic [15:0] a, input logic [7:0] d, input logic w,
                             input logic [4:0] rq, input logic [4:0] ak);
      bit          tap_now, tick, treq;
      int unsigned dv;
      dv      = d;
      tap_now = m_tap(m_cnt, m_tac);
      tick    = m_tapq && !tap_now;
      treq    = m_reload && !(w && a == 16'hFF05);
      m_tapq  = tap_now;
      m_cnt   = (w && a == 16'hFF04) ? 0 : (m_cnt + 4) % 65536;
      if (w && a == 16'hFF05) begin
         m_tima = dv; m_reload = 0;
      end else if (m_reload) begin
         m_tima = (w && a == 16'hFF06) ? dv : m_tma; m_reload = 0;
      end else if (tick) begin
         if (m_tima == 255) begin m_tima = 0; m_reload = 1; end
         else m_tima = m_tima + 1;
      end
      if (w && a == 16'hFF06) m_tma = dv;
      if (w && a == 16'hFF07) m_tac = dv % 8;
      if (w && a == 16'hFFFF) m_ie = dv;
      m_if = ((((w && a == 16'hFF0F) ? dv % 32 : m_if) & ~int'(ak)) & 31)
             | int'(rq) | (treq ? 4 : 0);
   endtask

   function automatic logic [7:0] exp_read(input logic [15:0] a);
      case (a)
         16'hFF04: return 8'(m_cnt / 256);
         16'hFF05: return 8'(m_tima);
         16'hFF06: return 8'(m_tma);
         16'hFF07: return 8'(248 + m_tac);
         16'hFF0F: return 8'(224 + m_if);
         16'hFFFF: return 8'(m_ie);
         default:  return 8'hFF;
      endcase
   endfunction

   function automatic logic exp_sel(input logic [15:0] a);
      return a == 16'hFF04 || a == 16'hFF05 || a == 16'hFF06 || a == 16'hFF07 ||
             a == 16'hFF0F || a == 16'hFFFF;
   endfunction

   task automatic check_all();
      chk("data_o", data_o, exp_read(addr_i));
      chk("sel_o", {7'd0, sel_o}, {7'd0, exp_sel(addr_i)});
      chk("reg_IF", reg_IF, 8'(m_if));
      chk("reg_IE", reg_IE, 8'(m_ie));
   endtask

   task automatic cycle(input logic [15:0] a, input logic [7:0] d, input logic w,
                        input logic [4:0] rq, input logic [4:0] ak);
      addr_i = a; data_i = d; wren_i = w; irq_req_i = rq; irq_ack_i = ak;
      @(posedge clk);
      model_step(a, d, w, rq, ak);
      #1;
      check_all();
   endtask

   initial begin
      logic [15:0] addrs [6];
      logic [15:0] a;
      logic [7:0]  d, prev;
      logic        w;
      logic [4:0]  rq, ak;
      bit          found;

      addrs[0] = 16'hFF04; addrs[1] = 16'hFF05; addrs[2] = 16'hFF06;
      addrs[3] = 16'hFF07; addrs[4] = 16'hFF0F; addrs[5] = 16'hFFFF;

      reset = 1'b1; addr_i = '0; data_i = '0; wren_i = 1'b0;
      irq_req_i = '0; irq_ack_i = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      #1;
      chk("rst_data", data_o, 8'hFF);
      chk("rst_sel", {7'd0, sel_o}, 8'h00);
      chk("rst_if", reg_IF, 8'h00);
      chk("rst_ie", reg_IE, 8'h00);

      // DIV after 64 clk, then DIV write clears it
      repeat (64) cycle(16'hFF04, 8'h00, 1'b0, '0, '0);
      chk("div_64clk", data_o, 8'h01);
      cycle(16'hFF04, 8'h5A, 1'b1, '0, '0);
      chk("div_clear", data_o, 8'h00);

      // overflow: FF -> 00 for one cycle -> TMA with timer IF
      cycle(16'hFF07, 8'h05, 1'b1, '0, '0);
      cycle(16'hFF06, 8'h80, 1'b1, '0, '0);
      cycle(16'hFF05, 8'hFE, 1'b1, '0, '0);
      prev = 8'hFE; found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(16'hFF05, 8'h00, 1'b0, '0, '0);
         if (data_o == 8'h00) begin
            found = 1;
            chk("ovf_prev_ff", prev, 8'hFF);
            chk("ovf_if_quiet", reg_IF, 8'h00);
         end else prev = data_o;
      end
      chk("ovf_seen", {7'd0, found}, 8'h01);
      cycle(16'hFF05, 8'h00, 1'b0, '0, '0);
      chk("ovf_tma", data_o, 8'h80);
      chk("ovf_if_timer", reg_IF, 8'h04);

      // TIMA write in the RELOAD cycle cancels reload and interrupt
      cycle(16'hFF0F, 8'h00, 1'b1, '0, '0);
      cycle(16'hFF05, 8'hFF, 1'b1, '0, '0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(16'hFF05, 8'h00, 1'b0, '0, '0);
         if (data_o == 8'h00) found = 1;
      end
      chk("cancel_seen", {7'd0, found}, 8'h01);
      cycle(16'hFF05, 8'h33, 1'b1, '0, '0);
      chk("cancel_tima", data_o, 8'h33);
      chk("cancel_if", reg_IF, 8'h00);
      cycle(16'hFF05, 8'h00, 1'b0, '0, '0);
      chk("cancel_if_late", reg_IF, 8'h00);

      // IE write, request set, read-back, ack clear
      cycle(16'hFFFF, 8'h1F, 1'b1, '0, '0);
      chk("ie_write", reg_IE, 8'h1F);
      cycle(16'hFF0F, 8'h00, 1'b0, 5'b00001, '0);
      chk("req_if", reg_IF, 8'h01);
      chk("req_read", data_o, 8'hE1);
      cycle(16'hFF0F, 8'h00, 1'b0, '0, 5'b00001);
      chk("ack_if", reg_IF, 8'h00);

      // set request beats simultaneous IF write
      cycle(16'hFF0F, 8'h00, 1'b1, 5'b01000, '0);
      chk("set_wins", reg_IF, 8'h08);

      // DIV write while tap is high produces one tick
      cycle(16'hFF04, 8'h00, 1'b1, '0, '0);
      cycle(16'hFF05, 8'h40, 1'b1, '0, '0);
      cycle(16'hFF05, 8'h00, 1'b0, '0, '0);
      cycle(16'hFF04, 8'h00, 1'b1, '0, '0);
      addr_i = 16'hFF05; #1;
      chk("divtick_before", data_o, 8'h40);
      cycle(16'hFF05, 8'h00, 1'b0, '0, '0);
      chk("divtick_after", data_o, 8'h41);

      // reset asserted in RELOAD
      cycle(16'hFF05, 8'hFF, 1'b1, '0, '0);
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         cycle(16'hFF05, 8'h00, 1'b0, '0, '0);
         if (data_o == 8'h00) found = 1;
      end
      chk("rstrl_seen", {7'd0, found}, 8'h01);
      #2 reset = 1'b1; addr_i = 16'h0000;
      model_reset();
      #1;
      chk("rstrl_data", data_o, 8'hFF);
      chk("rstrl_sel", {7'd0, sel_o}, 8'h00);
      chk("rstrl_if", reg_IF, 8'h00);
      chk("rstrl_ie", reg_IE, 8'h00);
      addr_i = 16'hFF06; #1;
      chk("rstrl_tma", data_o, 8'h00);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      cycle(16'hFF0F, 8'h00, 1'b0, '0, '0);
      chk("rstrl_if_after", reg_IF, 8'h00);
      cycle(16'hFF05, 8'h00, 1'b0, '0, '0);
      chk("rstrl_tima_after", data_o, 8'h00);

      // randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         int unsigned r;
         r = $urandom_range(0, 7);
         a = (r < 6) ? addrs[r] : 16'($urandom);
         w = ($urandom_range(0, 3) == 0);
         if (a == 16'hFF04 && $urandom_range(0, 7) != 0) w = 1'b0;
         d = 8'($urandom);
         if (a == 16'hFF05 && $urandom_range(0, 1) == 0) d = d | 8'hF0;
         if (a == 16'hFF07 && $urandom_range(0, 1) == 0) d = d | 8'h04;
         rq = ($urandom_range(0, 7) == 0) ? 5'($urandom) : 5'd0;
         ak = ($urandom_range(0, 3) == 0) ? 5'(1 << $urandom_range(0, 4)) : 5'd0;
         cycle(a, d, w, rq, ak);
      end

      wren_i = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
